// File: rtl/wall_datapath.sv
// Scrolling wall datapath: wall/gap position, passed-wall count, collision flag,
// and an erase/draw pixel sweep feeding the VGA adapter.
module wall_datapath #(
    parameter int unsigned X_START     = 152,
    parameter int unsigned WALL_W      = 4,
    parameter int unsigned GAP_H       = 32,
    parameter int unsigned PLAYER_W    = 4,
    parameter int unsigned PLAYER_H    = 4,
    parameter int unsigned TICK_DIV    = 833333,
    parameter logic [2:0]  WALL_COLOUR = 3'b010
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] state,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    output logic       touched,
    output logic [7:0] wall_x,
    output logic [7:0] passed,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

    localparam int unsigned ROWS = 120;
    localparam int unsigned TW   = $clog2(TICK_DIV);
    localparam int unsigned CW   = (WALL_W > 1) ? $clog2(WALL_W) : 1;
    localparam logic [3:0]  ST_READY = 4'd5;
    localparam logic [3:0]  ST_MOVE  = 4'd6;
    localparam logic [3:0]  ST_DRAW  = 4'd8;
    localparam logic [6:0]  LFSR_SEED = 7'h5A;

    typedef enum logic [1:0] {SW_IDLE, SW_ERASE, SW_DRAW} sweep_t;

    function automatic logic [6:0] gap_of(input logic [6:0] l);
        return 7'd8 + {1'b0, l[5:0]};
    endfunction

    logic [6:0]    lfsr, gap_y, lfsr_next;
    logic [TW-1:0] tick_q;
    logic          move_due, tick_end, draw_req;

    assign lfsr_next = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    assign tick_end  = (tick_q == TW'(TICK_DIV - 1));
    assign draw_req  = (state == ST_DRAW);

    // Wall position, gap, move timing and passed count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wall_x   <= 8'(X_START);
            lfsr     <= LFSR_SEED;
            gap_y    <= gap_of(LFSR_SEED);
            passed   <= 8'd0;
            tick_q   <= '0;
            move_due <= 1'b0;
        end else if (state == ST_READY) begin
            wall_x   <= 8'(X_START);
            gap_y    <= gap_of(lfsr);
            tick_q   <= '0;
            move_due <= 1'b0;
        end else if (state == ST_MOVE || state == ST_DRAW) begin
            tick_q <= tick_end ? '0 : tick_q + TW'(1);
            if (state == ST_MOVE && move_due) begin
                move_due <= 1'b0;
                if (wall_x != 8'd0) begin
                    wall_x <= wall_x - 8'd1;
                end else begin
                    wall_x <= 8'(X_START);
                    lfsr   <= lfsr_next;
                    gap_y  <= gap_of(lfsr_next);
                    if (passed != 8'hFF) passed <= passed + 8'd1;
                end
            end
            if (tick_end) move_due <= 1'b1;
        end
    end

    // Collision: box overlap in x, not fully inside the gap in y (9-bit math).
    logic [8:0] wx9, px9, py9, gy9;
    logic       xo, in_gap;
    assign wx9    = {1'b0, wall_x};
    assign px9    = {1'b0, player_x};
    assign py9    = {2'b00, player_y};
    assign gy9    = {2'b00, gap_y};
    assign xo     = (px9 <= wx9 + 9'(WALL_W - 1)) && (wx9 <= px9 + 9'(PLAYER_W - 1));
    assign in_gap = (py9 >= gy9) && (py9 + 9'(PLAYER_H - 1) <= gy9 + 9'(GAP_H - 1));

    always_ff @(posedge clk) begin
        if (!resetn) touched <= 1'b0;
        else         touched <= (state != ST_READY) && xo && !in_gap;
    end

    // Sweep FSM state and scan registers.
    sweep_t        sw_q, sw_nxt;
    logic [CW-1:0] col_q, col_nxt;
    logic [6:0]    row_q, row_nxt, sg_q, sg_nxt;
    logic [7:0]    sx_q, sx_nxt, last_x_q, last_x_nxt, pix_base;
    logic          last_valid_q, last_valid_nxt, pend_q, pend_nxt, start, pix_in_gap;

    always_ff @(posedge clk) begin
        if (!resetn) sw_q <= SW_IDLE;
        else         sw_q <= sw_nxt;
    end

    always_comb begin
        sw_nxt         = sw_q;
        col_nxt        = col_q;
        row_nxt        = row_q;
        sx_nxt         = sx_q;
        sg_nxt         = sg_q;
        last_x_nxt     = last_x_q;
        last_valid_nxt = last_valid_q;
        pend_nxt       = pend_q;
        start          = 1'b0;
        pix_base       = 8'd0;
        pix_in_gap     = 1'b0;
        case (sw_q)
            SW_IDLE: start = draw_req;
            default: begin
                if (draw_req) pend_nxt = 1'b1;
                if (row_q == 7'(ROWS - 1)) begin
                    row_nxt = 7'd0;
                    if (col_q == CW'(WALL_W - 1)) begin
                        col_nxt = '0;
                        if (sw_q == SW_ERASE) begin
                            sw_nxt = SW_DRAW;
                        end else begin
                            last_x_nxt     = sx_q;
                            last_valid_nxt = 1'b1;
                            if (pend_q || draw_req) begin
                                start    = 1'b1;
                                pend_nxt = 1'b0;
                            end else begin
                                sw_nxt = SW_IDLE;
                            end
                        end
                    end else begin
                        col_nxt = col_q + CW'(1);
                    end
                end else begin
                    row_nxt = row_q + 7'd1;
                end
            end
        endcase
        if (start) begin
            sx_nxt  = wall_x;
            sg_nxt  = gap_y;
            col_nxt = '0;
            row_nxt = 7'd0;
            sw_nxt  = last_valid_nxt ? SW_ERASE : SW_DRAW;
        end
        // Pixel for the cycle after this edge comes from the next-state scan position.
        pix_base   = (sw_nxt == SW_ERASE) ? last_x_nxt : sx_nxt;
        pix_in_gap = ({1'b0, row_nxt} >= {1'b0, sg_nxt}) &&
                     ({1'b0, row_nxt} <= {1'b0, sg_nxt} + 8'(GAP_H - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q        <= '0;
            row_q        <= 7'd0;
            sx_q         <= 8'd0;
            sg_q         <= 7'd0;
            last_x_q     <= 8'd0;
            last_valid_q <= 1'b0;
            pend_q       <= 1'b0;
            vga_x        <= 8'd0;
            vga_y        <= 7'd0;
            vga_colour   <= 3'd0;
            vga_plot     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            col_q        <= col_nxt;
            row_q        <= row_nxt;
            sx_q         <= sx_nxt;
            sg_q         <= sg_nxt;
            last_x_q     <= last_x_nxt;
            last_valid_q <= last_valid_nxt;
            pend_q       <= pend_nxt;
            vga_plot     <= (sw_nxt != SW_IDLE);
            busy         <= (sw_nxt != SW_IDLE);
            if (sw_nxt != SW_IDLE) begin
                vga_x      <= pix_base + 8'(col_nxt);
                vga_y      <= row_nxt;
                vga_colour <= (sw_nxt == SW_DRAW && !pix_in_gap) ? WALL_COLOUR : 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_wall_datapath.sv
// Directed self-checking bench for wall_datapath.
module tb_wall_datapath;

    localparam int unsigned TICK = 1000;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] state;
    logic [7:0] player_x;
    logic [6:0] player_y;
    logic       touched, vga_plot, busy;
    logic [7:0] wall_x, passed, vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    always #5 clk = ~clk;

    wall_datapath #(.TICK_DIV(TICK)) dut (
        .clk(clk), .resetn(resetn), .state(state), .player_x(player_x), .player_y(player_y),
        .touched(touched), .wall_x(wall_x), .passed(passed), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
    );

    typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
    pix_t cap[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Record plots from the current cycle until busy drops.
    task automatic capture(output int timeout);
        cap.delete();
        timeout = 1;
        for (int i = 0; i < 5000; i++) begin
            if (vga_plot) cap.push_back({vga_x, vga_y, vga_colour});
            if (!busy) begin
                timeout = 0;
                break;
            end
            step(1);
        end
    endtask

    function automatic int cap_c(input int idx);
        if (idx >= cap.size()) return -1;
        return int'(cap[idx].c);
    endfunction

    // Mismatching pixels in a 480-pixel column-major block starting at off.
    function automatic int bad_block(input int off, input int sx, input int sg, input bit erase);
        int bad = 0;
        if (cap.size() < off + 480) return 480;
        for (int i = 0; i < 480; i++) begin
            int col = i / 120;
            int row = i % 120;
            int ec  = (erase || (row >= sg && row <= sg + 31)) ? 0 : 2;
            if (int'(cap[off+i].x) != sx + col || int'(cap[off+i].y) != row ||
                int'(cap[off+i].c) != ec) bad++;
        end
        return bad;
    endfunction

    initial begin
        int to, moves, plots, prev, done;
        int tv [9][3] = '{'{150,10,1}, '{150,40,0}, '{153,10,0}, '{146,10,1}, '{145,10,0},
                          '{150,33,1}, '{150,34,0}, '{150,62,0}, '{150,63,1}};
        resetn = 1'b0; state = 4'd5; player_x = 8'd0; player_y = 7'd0;
        step(2);
        resetn = 1'b1;
        step(3);
        check("rst_wall_x", wall_x, 152);
        check("rst_gap_y", dut.gap_y, 34);
        check("rst_touched", touched, 0);
        check("rst_passed", passed, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_busy", busy, 0);

        // First draw: no erase, plot starts the cycle after the request edge.
        state = 4'd8; step(1); state = 4'd7;
        check("first_plot", vga_plot, 1);
        check("first_x", vga_x, 152);
        check("first_y", vga_y, 0);
        check("first_c", vga_colour, 2);
        capture(to);
        check("draw1_timeout", to, 0);
        check("draw1_count", cap.size(), 480);
        check("draw1_bad", bad_block(0, 152, 34, 1'b0), 0);
        check("row33_c", cap_c(33), 2);
        check("row34_c", cap_c(34), 0);
        check("row65_c", cap_c(65), 0);
        check("row66_c", cap_c(66), 2);
        check("idle_plot", vga_plot, 0);

        // Second draw: erase of the old columns precedes the draw.
        state = 4'd8; step(1); state = 4'd7;
        capture(to);
        check("draw2_timeout", to, 0);
        check("draw2_count", cap.size(), 960);
        check("erase_bad", bad_block(0, 152, 0, 1'b1), 0);
        check("draw2_bad", bad_block(480, 152, 34, 1'b0), 0);

        // Move timing with alternating MOVE/DRAW.
        state = 4'd5; step(3);
        moves = 0; prev = wall_x;
        for (int k = 0; k <= 3000; k++) begin
            state = (k % 2 == 0 || k == 3000) ? 4'd6 : 4'd8;
            step(1);
            if (int'(wall_x) != prev) moves++;
            prev = wall_x;
        end
        state = 4'd7;
        check("move_wall_x", wall_x, 149);
        check("move_count", moves, 3);
        done = 0;
        for (int i = 0; i < 3000 && done == 0; i++) begin
            if (!busy) done = 1;
            else step(1);
        end
        check("drain_done", done, 1);

        // Collision vectors against wall 149..152, gap 34..65.
        foreach (tv[i]) begin
            player_x = 8'(tv[i][0]); player_y = 7'(tv[i][1]);
            step(1);
            check($sformatf("touch_%0d_%0d", tv[i][0], tv[i][1]), touched, tv[i][2]);
        end
        player_x = 8'd150; player_y = 7'd10; state = 4'd5; step(1);
        check("touch_ready", touched, 0);
        player_x = 8'd0; player_y = 7'd0;

        // Wrap: move every MOVE cycle, 152 -> 0 -> wrap.
        force dut.move_due = 1'b1;
        state = 4'd6;
        for (int i = 0; i < 200 && wall_x != 8'd0; i++) step(1);
        check("at_zero", wall_x, 0);
        step(1);
        state = 4'd7;
        step(1);
        check("wrap_wall_x", wall_x, 152);
        check("wrap_passed", passed, 1);
        check("wrap_lfsr", dut.lfsr, 7'h35);
        check("wrap_gap_y", dut.gap_y, 61);
        state = 4'd6;
        step(254 * 153);
        check("sat_reach", passed, 255);
        check("sat_wall_x", wall_x, 152);
        step(153);
        check("sat_hold", passed, 255);
        state = 4'd7;
        step(1);
        release dut.move_due;

        // Two requests during one sweep coalesce into one extra sweep.
        state = 4'd5; step(3);
        state = 4'd8; step(1);
        plots = 0; done = 0;
        for (int i = 0; i < 5000 && done == 0; i++) begin
            if (vga_plot) plots++;
            if (!busy) done = 1;
            else begin
                state = (i == 100 || i == 151) ? 4'd8 : 4'd7;
                step(1);
            end
        end
        state = 4'd7;
        check("pend_done", done, 1);
        check("pend_plots", plots, 1920);
        plots = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (vga_plot) plots++;
        end
        check("pend_quiet", plots, 0);

        // Reset mid-sweep aborts it.
        state = 4'd8; step(1); state = 4'd7; step(50);
        check("mid_busy", busy, 1);
        resetn = 1'b0; step(1);
        check("mid_rst_plot", vga_plot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_passed", passed, 0);
        check("mid_rst_gap", dut.gap_y, 34);
        resetn = 1'b1; step(1);
        state = 4'd8; step(1); state = 4'd7;
        capture(to);
        check("post_rst_timeout", to, 0);
        check("post_rst_count", cap.size(), 480);
        check("post_rst_first_c", cap_c(0), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
